fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the MIPS core, wrapped around the program counter register. It reads the current PC and fetches the instruction at that address from instruction memory over a request/grant/response handshake. It presents the instruction to the decode stage with a valid/ready handshake. It computes the next PC (sequential, branch, jump, jump-register) that the PC register captures on the following edge.

## Interface

Parameters:
- TIMEOUT, 16: maximum cycles waiting in S_WAIT for imem_rvalid before declaring a fetch error; legal range 1..255.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- pc_in  input  32  current PC, taken from the PC register output.
- pc_next  output  32  value the PC register loads every edge; equals pc_in whenever the PC must hold.
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  request address; always equals pc_in.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  imem_rdata is valid this cycle.
- imem_rdata  input  32  instruction word.
- instr_out  output  32  fetched instruction (registered).
- instr_pc  output  32  address of instr_out (registered).
- instr_valid  output  1  instr_out and instr_pc are valid.
- instr_ready  input  1  decode consumes the instruction this cycle.
- branch_taken  input  1  conditional branch resolved taken; sampled only at retire.
- branch_offset  input  32  sign-extended 16-bit immediate, in words.
- jump  input  1  J/JAL.
- jump_index  input  26  instr_index field.
- jump_reg  input  1  JR/JALR.
- jr_target  input  32  register target.
- fetch_err  output  1  sticky fetch error.

## Operation

- States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR.
- S_IDLE: entered on reset. Goes to S_REQ after 1 cycle.
- S_REQ:
  - If pc_in[1:0] != 0, go to S_ERR. No request is issued.
  - Otherwise imem_req=1. If imem_gnt && imem_rvalid in the same cycle: latch imem_rdata→instr_out and pc_in→instr_pc, then go to S_HOLD.
  - Else if imem_gnt: go to S_WAIT and clear the timer.
  - Else stay in S_REQ. imem_rvalid without imem_gnt is ignored.
- S_WAIT: imem_req=0.
  - If imem_rvalid: latch instr_out and instr_pc, then go to S_HOLD.
  - Else increment the timer. When the timer reaches TIMEOUT-1 without imem_rvalid, go to S_ERR.
- S_HOLD: instr_valid=1. instr_out and instr_pc are stable. Retire occurs on instr_ready=1, then go to S_REQ.
- S_ERR: fetch_err=1, instr_valid=0, imem_req=0, pc_next=pc_in. Exit only by Reset.
- pc_next arithmetic is modulo 2^32 (wrap, no flag). pc4 = pc_in+4.
  - pc_next = pc_in in every cycle except retire.
  - At retire, priority is jump_reg > jump > branch_taken > sequential:
    - jump_reg: jr_target. jr_target is not alignment-checked here; a misaligned target errors in the next S_REQ.
    - jump: {pc4[31:28], jump_index, 2'b00}.
    - branch_taken: pc4 + (branch_offset<<2), with the shift truncated to 32 bits.
    - Sequential: pc4.
- Redirect inputs are ignored outside the retire cycle.

## Timing

- Reset values: state S_IDLE, instr_out 0, instr_pc 0, instr_valid 0, fetch_err 0, timer 0, imem_req 0. pc_next follows pc_in (0).
- Reset mid-transaction, in any state: immediate return to S_IDLE. Any outstanding imem_rvalid arriving after reset is ignored.
- imem_req, imem_addr, instr_valid and fetch_err are decoded from state. No combinational path exists from imem inputs to imem_req.
- pc_next is combinational from state, instr_ready, pc_in and the redirect inputs.
- Minimum throughput is 2 cycles per instruction: S_REQ with gnt+rvalid, then S_HOLD with instr_ready.
- The PC register updates at the retire edge. The next S_REQ therefore sees the new pc_in.
- Latency from reset release to the first imem_req is 1 cycle.
- Decode stall: S_HOLD holds indefinitely and pc_next=pc_in.

## Test plan

- Zero-wait memory, reset, instr_ready=1 always:
  - imem_req is first seen 1 cycle after release, at addr 0.
  - Instructions at 0x0, 0x4, 0x8 are retired on alternating cycles.
- gnt delayed 3 cycles, rvalid 2 cycles after gnt, ready held low 4 cycles:
  - instr_out is stable through the stall.
  - pc_next=pc_in until the retire.
- Branch at pc 0x100 with offset 0xFFFFFFFE (-2) -> pc_next=0xFC.
  - With jump=1 and jump_index=0x0000010 also asserted -> 0x40.
  - jump_reg=1 with jr_target=0x2000 overrides both.
- Sequential wrap: pc 0xFFFFFFFC retires -> pc_next=0x00000000, no error.
- Misaligned target: jr_target=0x1002 -> next S_REQ asserts no imem_req and fetch_err=1. fetch_err stays set until Reset low.
- Timeout and reset: TIMEOUT=4, gnt given, rvalid never -> fetch_err after 4 S_WAIT cycles. A separate run pulses Reset low during S_WAIT, after which:
  - all outputs return to their reset values;
  - a late rvalid is ignored;
  - fetch restarts at addr 0.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction-fetch stage around the PC register
// Fetches the word at pc_in over req/gnt/rvalid, hands it to decode, computes pc_next.
module fetch_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_target,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] instr_out_q, instr_out_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [7:0]  timer_q, timer_d;

    logic        aligned;
    logic        retire;
    logic [31:0] pc4;
    logic [31:0] offset_bytes;

    assign aligned = (pc_in[1:0] == 2'b00);
    assign retire  = (state_q == S_HOLD) && instr_ready;

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            instr_out_q <= 32'h0;
            instr_pc_q  <= 32'h0;
            timer_q     <= 8'h0;
        end else begin
            state_q     <= state_d;
            instr_out_q <= instr_out_d;
            instr_pc_q  <= instr_pc_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_out_d = instr_out_q;
        instr_pc_d  = instr_pc_q;
        timer_d     = timer_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // A misaligned PC never reaches memory; rvalid without gnt is stale.
                if (!aligned) begin
                    state_d = S_ERR;
                end else if (imem_gnt && imem_rvalid) begin
                    instr_out_d = imem_rdata;
                    instr_pc_d  = pc_in;
                    state_d     = S_HOLD;
                end else if (imem_gnt) begin
                    timer_d = 8'h0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_out_d = imem_rdata;
                    instr_pc_d  = pc_in;
                    state_d     = S_HOLD;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (instr_ready) state_d = S_REQ;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    assign pc4          = pc_in + 32'd4;
    assign offset_bytes = branch_offset << 2;

    // The PC register loads pc_next every edge, so holding means echoing pc_in.
    always_comb begin
        pc_next = pc_in;
        if (retire) begin
            if (jump_reg)          pc_next = jr_target;
            else if (jump)         pc_next = {pc4[31:28], jump_index, 2'b00};
            else if (branch_taken) pc_next = pc4 + offset_bytes;
            else                   pc_next = pc4;
        end
    end

    assign imem_req    = (state_q == S_REQ) && aligned;
    assign imem_addr   = pc_in;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == S_HOLD);
    assign fetch_err   = (state_q == S_ERR);

endmodule
